// File: rtl/sync_counter_pkg.sv
// Shared types and helpers for the synchronous up/down modulo counter family.
package sync_counter_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam int MIN_MAX   = 1;
  localparam int MIN_PRESC = 1;

  // A one-cycle prescaler still needs a 1-bit register to keep widths legal.
  function automatic int presc_width(input int presc);
    return (presc <= 1) ? 1 : $clog2(presc);
  endfunction

  function automatic bit params_legal(input int n, input int max, input int presc);
    longint full;
    full = (longint'(1) << n) - 1;
    return (max >= MIN_MAX) && (longint'(max) <= full) && (presc >= MIN_PRESC);
  endfunction

endpackage

// File: rtl/count_prescaler.sv
// Divides enabled cycles by PRESC; step is high on the last cycle of each group.
// clr restarts the group; adv low freezes the phase.
module count_prescaler
  import sync_counter_pkg::*;
#(
  parameter int PRESC = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic adv,
  output logic step
);

  localparam int PW = presc_width(PRESC);
  localparam logic [PW-1:0] LAST = PW'(PRESC - 1);

  logic [PW-1:0] r_pre;
  logic          w_last;

  assign w_last = (r_pre == LAST);
  assign step   = adv & w_last;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pre <= '0;
    end else if (clr) begin
      r_pre <= '0;
    end else if (adv) begin
      r_pre <= w_last ? '0 : r_pre + 1'b1;
    end
  end

endmodule

// File: rtl/sync_updown_mod_counter.sv
// Up/down modulo-(MAX+1) counter with load, prescaler and one-shot halt.
// Registered outputs; a load or step shows on q one cycle after its edge.
module sync_updown_mod_counter
  import sync_counter_pkg::*;
#(
  parameter int N     = 4,
  parameter int MAX   = 2**N - 1,
  parameter int PRESC = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         up,
  input  logic         oneshot,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         done
);

  generate
    if (!params_legal(N, MAX, PRESC)) begin : g_param_check
      $error("sync_updown_mod_counter: illegal N/MAX/PRESC combination");
    end
  endgenerate

  localparam logic [N-1:0] MAX_Q = N'(MAX);

  state_t       r_state, w_state_nxt;
  logic [N-1:0] r_q, w_q_nxt;
  logic         r_tc, w_tc_nxt;
  logic         r_done, w_done_nxt;
  logic         w_adv;
  logic         w_step;
  logic [N-1:0] w_term;

  assign w_adv = en & (r_state == RUN);

  count_prescaler #(
    .PRESC(PRESC)
  ) u_presc (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (load),
    .adv    (w_adv),
    .step   (w_step)
  );

  assign w_term = up ? MAX_Q : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= RUN;
      r_q     <= '0;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_tc    <= w_tc_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Wrap targets are explicit so arithmetic stays modulo MAX+1, not 2**N.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_tc_nxt    = 1'b0;
    w_done_nxt  = r_done;
    if (load) begin
      w_q_nxt     = (d > MAX_Q) ? MAX_Q : d;
      w_done_nxt  = 1'b0;
      w_state_nxt = RUN;
    end else if (w_step) begin
      if (r_q != w_term) begin
        w_q_nxt = up ? r_q + 1'b1 : r_q - 1'b1;
      end else if (!oneshot) begin
        w_q_nxt  = up ? '0 : MAX_Q;
        w_tc_nxt = 1'b1;
      end else begin
        w_tc_nxt    = 1'b1;
        w_done_nxt  = 1'b1;
        w_state_nxt = HALT;
      end
    end
  end

  assign q    = r_q;
  assign tc   = r_tc;
  assign done = r_done;

endmodule

// File: tb/tb_sync_updown_mod_counter.sv
// Directed bench: two instances (PRESC=1 and PRESC=3, both N=4 MAX=9) on shared stimulus.
module tb_sync_updown_mod_counter;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic       up;
  logic       oneshot;
  logic       load;
  logic [3:0] d;
  logic [3:0] a_q, b_q;
  logic       a_tc, b_tc;
  logic       a_done, b_done;

  int n_checks = 0;
  int n_errors = 0;

  sync_updown_mod_counter #(.N(4), .MAX(9), .PRESC(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .oneshot(oneshot),
    .load(load), .d(d), .q(a_q), .tc(a_tc), .done(a_done)
  );

  sync_updown_mod_counter #(.N(4), .MAX(9), .PRESC(3)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .oneshot(oneshot),
    .load(load), .d(d), .q(b_q), .tc(b_tc), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input int eq, input int etc, input int edone);
    check_eq({tag, ".q"},    int'(a_q),    eq);
    check_eq({tag, ".tc"},   int'(a_tc),   etc);
    check_eq({tag, ".done"}, int'(a_done), edone);
  endtask

  int exp_up[11]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
  int exp_dn[4]    = '{1, 0, 9, 8};
  int exp_dntc[4]  = '{0, 0, 1, 0};
  int os_q[5]      = '{8, 9, 9, 9, 9};
  int os_tc[5]     = '{0, 0, 1, 0, 0};
  int os_done[5]   = '{0, 0, 1, 1, 1};
  int ps_en[7]     = '{1, 1, 0, 1, 1, 1, 1};
  int ps_q[7]      = '{0, 0, 0, 1, 1, 1, 2};

  initial begin
    reset_n = 1'b0; en = 1'b0; up = 1'b1; oneshot = 1'b0; load = 1'b0; d = '0;
    tick();
    check_a("reset", 0, 0, 0);
    check_eq("reset.b_q", int'(b_q), 0);

    // Free-running up count wraps 9 -> 0 with a tc pulse.
    reset_n = 1'b1; en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      check_a($sformatf("up%0d", i), exp_up[i], (exp_up[i] == 0) ? 1 : 0, 0);
    end

    // en low freezes the count.
    en = 1'b0;
    tick(); tick();
    check_a("hold_en0", 1, 0, 0);
    en = 1'b1;

    // Down count from a load of 2 wraps 0 -> 9.
    load = 1'b1; d = 4'd2; up = 1'b0;
    tick();
    check_a("dn_load", 2, 0, 0);
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_a($sformatf("dn%0d", i), exp_dn[i], exp_dntc[i], 0);
    end

    // One-shot up from 7 stops at 9.
    up = 1'b1; oneshot = 1'b1; load = 1'b1; d = 4'd7;
    tick();
    check_a("os_load", 7, 0, 0);
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_a($sformatf("os%0d", i), os_q[i], os_tc[i], os_done[i]);
    end
    up = 1'b0;
    tick();
    check_a("halt_dirchg", 9, 0, 1);
    up = 1'b1;
    load = 1'b1; d = 4'd3;
    tick();
    check_a("os_reload", 3, 0, 0);

    // Load above MAX clamps.
    d = 4'd15;
    tick();
    check_a("clamp", 9, 0, 0);

    // Enter HALT, then reset and resume counting.
    d = 4'd9;
    tick();
    load = 1'b0;
    tick();
    check_a("halt_entry", 9, 1, 1);
    tick();
    check_a("halt_stay", 9, 0, 1);
    reset_n = 1'b0;
    tick();
    check_a("halt_reset", 0, 0, 0);
    reset_n = 1'b1;
    tick();
    check_a("resume", 1, 0, 0);

    // Reset beats a simultaneous load.
    reset_n = 1'b0; load = 1'b1; d = 4'd5;
    tick();
    check_a("rst_vs_load", 0, 0, 0);

    // Prescaler of 3: steps on the 3rd and 6th enabled cycles only.
    reset_n = 1'b1; load = 1'b1; d = 4'd0; oneshot = 1'b0; up = 1'b1;
    tick();
    check_eq("ps_load.b_q", int'(b_q), 0);
    load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      en = ps_en[i][0];
      tick();
      check_eq($sformatf("ps%0d.b_q", i), int'(b_q), ps_q[i]);
      check_eq($sformatf("ps%0d.b_tc", i), int'(b_tc), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
